// File: rtl/uart_rx_fsm.sv
// UART receive FSM; parity support is built only when UART_RX_PARITY_EN is defined.
// Result pulses land (1 + DATA_WIDTH + parity + 1) * prescale cycles after the start edge; no backpressure.
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_RX,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [5:0]            prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [5:0]            edge_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                r_state;
    logic [5:0]            r_edge_cnt;
    logic [5:0]            r_prescale;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_dv;
    logic                  r_se;
    logic                  r_busy;

    logic [5:0]            w_prescale_in;
    logic                  w_bit_end;

`ifdef UART_RX_PARITY_EN
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_fail;
    logic                  r_pe;
    logic                  w_par_expect;

    assign w_par_expect = (^r_shift) ^ r_par_typ;
`else
    logic                  w_unused_par;

    assign w_unused_par = PAR_EN ^ PAR_TYP;
`endif

    // Unsupported ratios fall back to 8x oversampling.
    always_comb begin
        case (prescale)
            6'd16:   w_prescale_in = 6'd16;
            6'd32:   w_prescale_in = 6'd32;
            default: w_prescale_in = 6'd8;
        endcase
    end

    assign w_bit_end = (r_edge_cnt == r_prescale - 6'd1);

    always_ff @(posedge clk_RX or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_edge_cnt <= '0;
            r_prescale <= 6'd8;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_dv       <= 1'b0;
            r_se       <= 1'b0;
            r_busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_fail <= 1'b0;
            r_pe       <= 1'b0;
`endif
        end else begin
            r_dv <= 1'b0;
            r_se <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_pe <= 1'b0;
`endif
            if (r_state == IDLE || w_bit_end) begin
                r_edge_cnt <= '0;
            end else begin
                r_edge_cnt <= r_edge_cnt + 6'd1;
            end

            case (r_state)
                IDLE: begin
                    if (!RX_IN) begin
                        r_state    <= START;
                        r_busy     <= 1'b1;
                        r_prescale <= w_prescale_in;
`ifdef UART_RX_PARITY_EN
                        r_par_en   <= PAR_EN;
                        r_par_typ  <= PAR_TYP;
                        r_par_fail <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        // A start bit that reads high at its end was line noise.
                        if (!sampled_bit) begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_shift   <= {sampled_bit, r_shift[DATA_WIDTH-1:1]};
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            r_state   <= r_par_en ? PARITY : STOP;
`else
                            r_state   <= STOP;
`endif
                        end
                    end
                end
                PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (w_bit_end) begin
                        r_par_fail <= (sampled_bit != w_par_expect);
                        r_state    <= STOP;
                    end
`else
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
`endif
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        if (sampled_bit && !r_par_fail) begin
                            r_data <= r_shift;
                            r_dv   <= 1'b1;
                        end else begin
                            r_pe <= r_par_fail;
                            r_se <= !sampled_bit;
                        end
`else
                        if (sampled_bit) begin
                            r_data <= r_shift;
                            r_dv   <= 1'b1;
                        end else begin
                            r_se <= 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign edge_cnt    = r_edge_cnt;
    assign P_DATA      = r_data;
    assign data_valid  = r_dv;
    assign stp_err     = r_se;
    assign busy        = r_busy;
    assign dat_samp_en = r_busy;
`ifdef UART_RX_PARITY_EN
    assign par_err     = r_pe;
`else
    assign par_err     = 1'b0;
`endif

endmodule
